// File: rtl/cnn_pkg.sv
// Constants and helpers shared by the convolution path. The window generator
// and the dot-product stage both use them.
package cnn_pkg;

    localparam int BIT_REP_IN_DEFAULT  = 8;
    localparam int KERNEL_SIZE_DEFAULT = 3;

    // Bit offset of window element (i,j) on the flattened dot-product bus.
    function automatic int win_offset(input int i, input int j, input int k, input int bits);
        return (i * k + j) * bits;
    endfunction

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel input stream and window output stream of the sliding-window generator.
// The master side feeds pixels and accepts windows; the slave side is the generator.
interface conv_window_gen_if
    import cnn_pkg::*;
#(
    parameter int K          = KERNEL_SIZE_DEFAULT,
    parameter int BIT_REP_IN = BIT_REP_IN_DEFAULT
);

    logic                      in_valid;
    logic                      in_ready;
    logic [BIT_REP_IN-1:0]     in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [K*K*BIT_REP_IN-1:0] out_window;
    logic                      out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_window, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_window, out_last
    );

endinterface

// File: rtl/conv_line_buffer.sv
// One image row of delay. The old pixel is read and the new pixel is written
// at the same column address.
module conv_line_buffer
    import cnn_pkg::*;
#(
    parameter int DEPTH = 28,
    parameter int WIDTH = BIT_REP_IN_DEFAULT,
    localparam int AW   = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // The read is asynchronous, so rdata shows the pixel from one row
    // earlier until the write commits on the edge.
    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming K x K sliding-window generator (stride 1, no padding). It feeds
// the dot-product stage and accepts back-to-back frames.
module conv_window_gen
    import cnn_pkg::*;
#(
    parameter int KERNEL_SIZE = KERNEL_SIZE_DEFAULT,
    parameter int BIT_REP_IN  = BIT_REP_IN_DEFAULT,
    parameter int IMG_W       = 28,
    parameter int IMG_H       = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    conv_window_gen_if.slave bus
);

    localparam int K     = KERNEL_SIZE;
    localparam int W     = BIT_REP_IN;
    localparam int COL_W = cnt_width(IMG_W);
    localparam int ROW_W = cnt_width(IMG_H);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_EMIT = COL_W'(K - 1);
    localparam logic [ROW_W-1:0] ROW_EMIT = ROW_W'(K - 1);

    logic [COL_W-1:0]            col;
    logic [ROW_W-1:0]            row;
    logic                        accept;
    logic                        emit;
    logic                        frame_end;
    logic [K-1:0][K-1:0][W-1:0]  win_q;
    logic [K-1:0][K-1:0][W-1:0]  win_next;
    logic [W-1:0]                lb_rd [K-1];
    logic [K*K*W-1:0]            window_flat;
    logic                        out_valid_q;
    logic                        out_last_q;
    logic [K*K*W-1:0]            out_window_q;

    assign bus.in_ready   = !out_valid_q || bus.out_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_last   = out_last_q;
    assign bus.out_window = out_window_q;

    assign accept    = bus.in_valid && bus.in_ready;
    assign emit      = (row >= ROW_EMIT) && (col >= COL_EMIT);
    assign frame_end = (row == ROW_LAST) && (col == COL_LAST);

    // Chain of row delays. Buffer n holds the row that is n+1 rows older
    // than the incoming pixel.
    for (genvar n = 0; n < K - 1; n++) begin : g_lb
        logic [W-1:0] wdata;
        if (n == 0) begin : g_head
            assign wdata = bus.in_data;
        end else begin : g_tail
            assign wdata = lb_rd[n-1];
        end
        conv_line_buffer #(
            .DEPTH (IMG_W),
            .WIDTH (W)
        ) u_lb (
            .clk   (clk),
            .we    (accept),
            .addr  (col),
            .wdata (wdata),
            .rdata (lb_rd[n])
        );
    end

    // Shift the window one column left. The new rightmost column runs from
    // the oldest buffered row (i=0) down to the incoming pixel.
    always_comb begin
        win_next = win_q;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K - 1; j++) begin
                win_next[i][j] = win_q[i][j+1];
            end
        end
        for (int i = 0; i < K - 1; i++) begin
            win_next[i][K-1] = lb_rd[K-2-i];
        end
        win_next[K-1][K-1] = bus.in_data;
    end

    always_comb begin
        window_flat = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                window_flat[win_offset(i, j, K, W) +: W] = win_next[i][j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col   <= '0;
            row   <= '0;
            win_q <= '0;
        end else if (accept) begin
            win_q <= win_next;
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // The output register loads only on a complete window. Stale columns
    // at the start of a row are therefore never presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_window_q <= '0;
        end else if (accept && emit) begin
            out_valid_q  <= 1'b1;
            out_last_q   <= frame_end;
            out_window_q <= window_flat;
        end else if (bus.out_ready) begin
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
        end
    end

endmodule
